watchdog_ctrl: RTL and testbench

//  Parametrised memory-mapped watchdog timer on the IO bus, next generation of the WDT.

---
 rtl/watchdog_ctrl_if.sv | 22 ++
 rtl/watchdog_ctrl.sv | 153 +++++++++++++++
 tb/tb_watchdog_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/watchdog_ctrl_if.sv
// IO-bus side of the watchdog: chip select, strobes, address/data, and the reset/irq outputs.
// The host drives the strobes (master); the watchdog answers with read data and its outputs (slave).
interface watchdog_ctrl_if #(parameter int WIDTH = 16);
  logic             watchdogCtrl;
  logic             write_enable;
  logic             read_enable;
  logic [1:0]       address;
  logic [WIDTH-1:0] write_data_in;
  logic [WIDTH-1:0] read_data_out;
  logic             WDT_output;
  logic             WDT_irq;

  modport master (
    output watchdogCtrl, write_enable, read_enable, address, write_data_in,
    input  read_data_out, WDT_output, WDT_irq
  );

  modport slave (
    input  watchdogCtrl, write_enable, read_enable, address, write_data_in,
    output read_data_out, WDT_output, WDT_irq
  );
endinterface

// File: rtl/watchdog_ctrl.sv
// Keyed watchdog with reload, prescaler, pre-timeout irq and config lock; updates on negedge clock.
// Reads are combinational, writes act on the next negedge; the bus is never stalled.
module watchdog_ctrl #(
  parameter int               WIDTH        = 16,
  parameter int               PRESCALE     = 1,
  parameter int               RST_CYCLES   = 4,
  parameter logic [WIDTH-1:0] KICK_KEY     = 16'h5A5A,
  parameter logic [WIDTH-1:0] DEFAULT_LOAD = 16'hFFFF
) (
  input  logic           clock,
  input  logic           reset,
  watchdog_ctrl_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_WARN  = 2'd2,
    S_FIRE  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_en, r_irq_en, r_lock, r_out, r_irq, r_badkey;
  logic [WIDTH-1:0] r_load, r_warn, r_counter;
  logic [PW-1:0]    r_presc, w_presc_nxt;
  logic [RW-1:0]    r_fire_cnt, w_fire_nxt;
  logic [WIDTH-1:0] w_cnt_nxt, w_cnt_dec, w_load_nxt, w_warn_nxt, w_rdata;
  logic             w_wr, w_rd, w_wr_ctrl, w_wr_load, w_wr_warn, w_kick, w_key_ok;
  logic             w_status_rd, w_tick, w_en_nxt, w_irq_en_nxt, w_out_nxt, w_badkey_set;

  assign w_wr        = bus.watchdogCtrl & bus.write_enable;
  assign w_rd        = bus.watchdogCtrl & bus.read_enable;
  assign w_wr_ctrl   = w_wr && (bus.address == 2'd0) && !r_lock;
  assign w_wr_load   = w_wr && (bus.address == 2'd1) && !r_lock;
  assign w_kick      = w_wr && (bus.address == 2'd2);
  assign w_wr_warn   = w_wr && (bus.address == 2'd3);
  assign w_status_rd = w_rd && (bus.address == 2'd3);
  assign w_key_ok    = (bus.write_data_in == KICK_KEY);

  // Configuration as it will be after this edge, so a write steers the FSM at the same edge.
  assign w_en_nxt     = w_wr_ctrl ? bus.write_data_in[0] : r_en;
  assign w_irq_en_nxt = w_wr_ctrl ? bus.write_data_in[1] : r_irq_en;
  assign w_load_nxt   = !w_wr_load ? r_load :
                        (bus.write_data_in == '0) ? WIDTH'(1) : bus.write_data_in;
  assign w_warn_nxt   = w_wr_warn ? bus.write_data_in : r_warn;
  assign w_tick       = (r_presc == PW'(PRESCALE - 1));
  assign w_cnt_dec    = r_counter - WIDTH'(1);

  always_ff @(negedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_counter;
    w_presc_nxt  = r_presc;
    w_fire_nxt   = r_fire_cnt;
    w_out_nxt    = 1'b0;
    w_badkey_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt   = w_load_nxt;
        w_presc_nxt = '0;
        if (w_en_nxt) w_state_nxt = S_COUNT;
      end
      S_COUNT, S_WARN: begin
        if (!w_en_nxt) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = w_load_nxt;
          w_presc_nxt = '0;
        end else if (w_kick && w_key_ok) begin
          w_state_nxt = S_COUNT;
          w_cnt_nxt   = w_load_nxt;
          w_presc_nxt = '0;
        end else if (w_kick || (w_tick && r_counter == '0)) begin
          w_state_nxt  = S_FIRE;
          w_cnt_nxt    = w_load_nxt;
          w_out_nxt    = 1'b1;
          w_fire_nxt   = '0;
          w_badkey_set = w_kick;
        end else if (w_tick) begin
          w_presc_nxt = '0;
          w_cnt_nxt   = w_cnt_dec;
          // A zero WARN threshold disables the warning phase entirely.
          if (r_state == S_COUNT && w_warn_nxt != '0 && w_cnt_dec <= w_warn_nxt)
            w_state_nxt = S_WARN;
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      default: begin
        w_cnt_nxt = w_load_nxt;
        w_out_nxt = 1'b1;
        if (r_fire_cnt == RW'(RST_CYCLES - 1)) begin
          w_out_nxt   = 1'b0;
          w_fire_nxt  = '0;
          w_presc_nxt = '0;
          w_state_nxt = w_en_nxt ? S_COUNT : S_IDLE;
        end else begin
          w_fire_nxt = r_fire_cnt + RW'(1);
        end
      end
    endcase
  end

  always_ff @(negedge clock) begin
    if (!reset) begin
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_lock     <= 1'b0;
      r_load     <= DEFAULT_LOAD;
      r_warn     <= '0;
      r_counter  <= DEFAULT_LOAD;
      r_presc    <= '0;
      r_fire_cnt <= '0;
      r_out      <= 1'b0;
      r_irq      <= 1'b0;
      r_badkey   <= 1'b0;
    end else begin
      r_en       <= w_en_nxt;
      r_irq_en   <= w_irq_en_nxt;
      if (w_wr_ctrl) r_lock <= bus.write_data_in[2];
      r_load     <= w_load_nxt;
      r_warn     <= w_warn_nxt;
      r_counter  <= w_cnt_nxt;
      r_presc    <= w_presc_nxt;
      r_fire_cnt <= w_fire_nxt;
      r_out      <= w_out_nxt;
      r_irq      <= (w_state_nxt == S_WARN) & w_irq_en_nxt;
      if (w_badkey_set)     r_badkey <= 1'b1;
      else if (w_status_rd) r_badkey <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (bus.address)
        2'd0:    w_rdata[2:0] = {r_lock, r_irq_en, r_en};
        2'd1:    w_rdata      = r_load;
        2'd2:    w_rdata      = r_counter;
        default: w_rdata[5:0] = {r_badkey, r_out, r_irq, r_lock, r_state};
      endcase
    end
  end

  assign bus.read_data_out = w_rdata;
  assign bus.WDT_output    = r_out;
  assign bus.WDT_irq       = r_irq;
endmodule

// File: tb/tb_watchdog_ctrl.sv
// Bench for watchdog_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_watchdog_ctrl;
  localparam int          W    = 16;
  localparam int          RSTC = 4;
  localparam int          PRE  = 1;
  localparam logic [15:0] KEY  = 16'h5A5A;

  logic clock = 1'b0;
  logic reset;

  watchdog_ctrl_if #(.WIDTH(W)) bus ();

  watchdog_ctrl #(
    .WIDTH(W), .PRESCALE(PRE), .RST_CYCLES(RSTC),
    .KICK_KEY(16'h5A5A), .DEFAULT_LOAD(16'hFFFF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Behavioural model: phase uses the STATUS encoding (0 idle, 1 count, 2 warn, 3 fire).
  logic        m_en, m_irq_en, m_lock, m_badkey;
  logic [15:0] m_load, m_warn, m_cnt;
  int          m_phase, m_pulse_left, m_pre;

  logic [15:0] rd_seen, rd_exp;
  logic        irq_pre;

  function automatic logic exp_out();
    return m_phase == 3;
  endfunction

  function automatic logic exp_irq();
    return (m_phase == 2) && m_irq_en;
  endfunction

  function automatic logic [15:0] exp_read(input logic act, input logic [1:0] a);
    logic [15:0] v;
    v = '0;
    if (act) begin
      case (a)
        2'd0:    v = {13'd0, m_lock, m_irq_en, m_en};
        2'd1:    v = m_load;
        2'd2:    v = m_cnt;
        default: v = {10'd0, m_badkey, exp_out(), exp_irq(), m_lock, 2'(m_phase)};
      endcase
    end
    return v;
  endfunction

  task automatic model_edge(input logic rst, input logic c, input logic we, input logic re,
                            input logic [1:0] a, input logic [15:0] d);
    logic wr, kick, clr, set_bk;
    if (!rst) begin
      m_en = 0; m_irq_en = 0; m_lock = 0; m_badkey = 0;
      m_load = 16'hFFFF; m_warn = 0; m_cnt = 16'hFFFF;
      m_phase = 0; m_pulse_left = 0; m_pre = 0;
      return;
    end
    wr = c & we;
    kick = wr && a == 2'd2;
    clr = c && re && a == 2'd3;
    set_bk = 0;
    if (wr && a == 2'd0 && !m_lock) begin
      m_en = d[0]; m_irq_en = d[1]; m_lock = d[2];
    end
    if (wr && a == 2'd1 && !m_lock) m_load = (d == 16'd0) ? 16'd1 : d;
    if (wr && a == 2'd3) m_warn = d;
    case (m_phase)
      0: begin
        m_cnt = m_load;
        if (m_en) begin m_phase = 1; m_pre = 0; end
      end
      1, 2: begin
        if (!m_en) begin
          m_phase = 0; m_cnt = m_load;
        end else if (kick && d == KEY) begin
          m_cnt = m_load; m_pre = 0; m_phase = 1;
        end else if (kick) begin
          set_bk = 1; m_phase = 3; m_pulse_left = RSTC; m_cnt = m_load;
        end else begin
          m_pre++;
          if (m_pre == PRE) begin
            m_pre = 0;
            if (m_cnt == 16'd0) begin
              m_phase = 3; m_pulse_left = RSTC; m_cnt = m_load;
            end else begin
              m_cnt = m_cnt - 16'd1;
              if (m_phase == 1 && m_warn != 16'd0 && m_cnt <= m_warn) m_phase = 2;
            end
          end
        end
      end
      default: begin
        m_cnt = m_load;
        m_pulse_left--;
        if (m_pulse_left == 0) begin
          m_phase = m_en ? 1 : 0; m_pre = 0;
        end
      end
    endcase
    if (clr) m_badkey = 0;
    if (set_bk) m_badkey = 1;
  endtask

  // One bus cycle: drive after posedge, capture combinational read data, let the negedge update.
  task automatic bus_cycle(input logic rst, input logic c, input logic we, input logic re,
                           input logic [1:0] a, input logic [15:0] d);
    reset = rst;
    bus.watchdogCtrl  = c;
    bus.write_enable  = we;
    bus.read_enable   = re;
    bus.address       = a;
    bus.write_data_in = d;
    #2;
    rd_seen = bus.read_data_out;
    irq_pre = bus.WDT_irq;
    rd_exp  = exp_read(c & re, a);
    @(negedge clock);
    model_edge(rst, c, we, re, a, d);
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus_cycle(1'b1, 1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    bus_cycle(1'b1, 1'b1, 1'b0, 1'b1, a, 16'd0);
  endtask

  task automatic idle();
    bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
  endtask

  task automatic hold_reset();
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
  endtask

  task automatic test_reset();
    hold_reset();
    total++;
    if (bus.WDT_output !== 1'b0) begin bad++; $display("FAIL reset_out got=%b want=0", bus.WDT_output); end
    total++;
    if (bus.WDT_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", bus.WDT_irq); end
    rd(2'd3);
    total++;
    if (rd_seen !== 16'h0000) begin bad++; $display("FAIL reset_status got=%h want=0000", rd_seen); end
    rd(2'd2);
    total++;
    if (rd_seen !== 16'hFFFF) begin bad++; $display("FAIL reset_count got=%h want=ffff", rd_seen); end
    idle();
    total++;
    if (rd_seen !== 16'h0000) begin bad++; $display("FAIL rd_unselected got=%h want=0000", rd_seen); end
  endtask

  task automatic test_warn_fire();
    int  hi = 0;
    bit  done = 0;
    bit  seen_irq = 0;
    wr(2'd1, 16'd10);
    wr(2'd3, 16'd3);
    wr(2'd0, 16'd3);
    for (int i = 0; i < 40 && !done; i++) begin
      rd(2'd2);
      total++;
      if (bus.WDT_output !== exp_out() || bus.WDT_irq !== exp_irq()) begin
        bad++;
        $display("FAIL warn_outputs cyc=%0d got=%b%b want=%b%b", i, bus.WDT_output, bus.WDT_irq, exp_out(), exp_irq());
      end
      if (irq_pre && !seen_irq) begin
        seen_irq = 1;
        total++;
        if (rd_seen !== 16'd3) begin bad++; $display("FAIL irq_count got=%0d want=3", rd_seen); end
      end
      if (bus.WDT_output) hi++;
      else if (hi > 0) done = 1;
    end
    total++;
    if (!seen_irq) begin bad++; $display("FAIL irq_rise got=0 want=1"); end
    total++;
    if (hi != 4) begin bad++; $display("FAIL pulse_len got=%0d want=4", hi); end
    rd(2'd2);
    total++;
    if (rd_seen !== 16'd10) begin bad++; $display("FAIL reload_after_fire got=%0d want=10", rd_seen); end
  endtask

  task automatic test_kick();
    wr(2'd1, 16'd10);
    wr(2'd0, 16'd1);
    for (int i = 0; i < 100; i++) begin
      if (i % 8 == 0) wr(2'd2, KEY);
      else idle();
      total++;
      if (bus.WDT_output !== 1'b0 || exp_out() !== 1'b0) begin
        bad++; $display("FAIL kick_hold cyc=%0d got=%b want=0", i, bus.WDT_output);
      end
    end
  endtask

  task automatic test_badkey();
    int hi = 1;
    wr(2'd2, 16'h1234);
    total++;
    if (bus.WDT_output !== 1'b1) begin bad++; $display("FAIL badkey_fire got=%b want=1", bus.WDT_output); end
    for (int i = 0; i < 10; i++) begin
      idle();
      if (bus.WDT_output) hi++;
    end
    total++;
    if (hi != 4) begin bad++; $display("FAIL badkey_pulse got=%0d want=4", hi); end
    rd(2'd3);
    total++;
    if (rd_seen[5] !== 1'b1) begin bad++; $display("FAIL badkey_first got=%b want=1", rd_seen[5]); end
    rd(2'd3);
    total++;
    if (rd_seen[5] !== 1'b0) begin bad++; $display("FAIL badkey_second got=%b want=0", rd_seen[5]); end
  endtask

  task automatic test_lock();
    int n = 0;
    bit fired = 0;
    hold_reset();
    wr(2'd1, 16'd10);
    wr(2'd0, 16'd5);
    wr(2'd0, 16'd0);
    wr(2'd1, 16'd2);
    rd(2'd0);
    total++;
    if (rd_seen !== 16'd5) begin bad++; $display("FAIL lock_ctrl got=%0d want=5", rd_seen); end
    rd(2'd1);
    total++;
    if (rd_seen !== 16'd10) begin bad++; $display("FAIL lock_load got=%0d want=10", rd_seen); end
    n = 4;
    for (int i = 0; i < 30 && !fired; i++) begin
      idle();
      n++;
      total++;
      if (bus.WDT_output !== exp_out()) begin bad++; $display("FAIL lock_out cyc=%0d got=%b want=%b", i, bus.WDT_output, exp_out()); end
      if (bus.WDT_output) fired = 1;
    end
    total++;
    if (!fired || n != 11) begin bad++; $display("FAIL lock_fire_edge got=%0d want=11", n); end
    hold_reset();
    rd(2'd0);
    total++;
    if (rd_seen !== 16'd0) begin bad++; $display("FAIL unlock_ctrl got=%0d want=0", rd_seen); end
    wr(2'd0, 16'd1);
    rd(2'd0);
    total++;
    if (rd_seen !== 16'd1) begin bad++; $display("FAIL unlock_write got=%0d want=1", rd_seen); end
  endtask

  task automatic test_reset_in_pulse();
    int hi;
    wr(2'd2, 16'h0BAD);
    total++;
    if (bus.WDT_output !== 1'b1) begin bad++; $display("FAIL abort_pulse_start got=%b want=1", bus.WDT_output); end
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    total++;
    if (bus.WDT_output !== 1'b0) begin bad++; $display("FAIL abort_pulse got=%b want=0", bus.WDT_output); end
    rd(2'd3);
    total++;
    if (rd_seen !== 16'd0) begin bad++; $display("FAIL abort_status got=%h want=0000", rd_seen); end
    wr(2'd0, 16'd1);
    wr(2'd2, 16'h0BAD);
    hi = 1;
    wr(2'd2, KEY);
    if (bus.WDT_output) hi++;
    wr(2'd2, 16'h0001);
    if (bus.WDT_output) hi++;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (bus.WDT_output) hi++;
    end
    total++;
    if (hi != 4) begin bad++; $display("FAIL fire_kick_ignored got=%0d want=4", hi); end
    rd(2'd3);
    total++;
    if (rd_seen !== rd_exp || rd_seen[5] !== 1'b1) begin bad++; $display("FAIL fire_status got=%h want=%h", rd_seen, rd_exp); end
  endtask

  task automatic test_random();
    logic        rst, c, we, re;
    logic [1:0]  a;
    logic [15:0] d;
    hold_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) >= 2);
      c   = ($urandom_range(0, 3) != 0);
      we  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      a   = 2'($urandom_range(0, 3));
      case (a)
        2'd0:    d = {13'd0, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0)};
        2'd1:    d = 16'($urandom_range(0, 12));
        2'd2:    d = ($urandom_range(0, 5) != 0) ? KEY : 16'($urandom);
        default: d = 16'($urandom_range(0, 6));
      endcase
      bus_cycle(rst, c, we, re, a, d);
      total++;
      if (rd_seen !== rd_exp) begin bad++; $display("FAIL rand_read cyc=%0d addr=%0d got=%h want=%h", i, a, rd_seen, rd_exp); end
      total++;
      if (bus.WDT_output !== exp_out()) begin bad++; $display("FAIL rand_out cyc=%0d got=%b want=%b", i, bus.WDT_output, exp_out()); end
      total++;
      if (bus.WDT_irq !== exp_irq()) begin bad++; $display("FAIL rand_irq cyc=%0d got=%b want=%b", i, bus.WDT_irq, exp_irq()); end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.watchdogCtrl  = 1'b0;
    bus.write_enable  = 1'b0;
    bus.read_enable   = 1'b0;
    bus.address       = 2'd0;
    bus.write_data_in = 16'd0;
    @(posedge clock);
    #1;
    test_reset();
    test_warn_fire();
    test_kick();
    test_badkey();
    test_lock();
    test_reset_in_pulse();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
